// File: rtl/ldpc_dec_addr_pkg.sv
// ldpc_dec_addr_pkg: shared widths, FSM states, command struct and circulant address helpers
package ldpc_dec_addr_pkg;
   localparam int C_N     = 8;
   localparam int ROW_N   = 4;
   localparam int Z_CYC   = 16;
   localparam int LLR_N   = 2;
   localparam int ADDR_W  = 8;
   localparam int ENG_LAT = 9;
   localparam int ITER_W  = 5;
   localparam int TAG_W   = 2;
   localparam int ROW_W   = $clog2(ROW_N);
   localparam int K_W     = $clog2(Z_CYC);
   localparam int SH_W    = $clog2(Z_CYC * LLR_N) + 1;
   localparam int SELA_W  = (LLR_N > 1) ? $clog2(LLR_N) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, READ, GAP, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [C_N-1:0][LLR_N-1:0][ADDR_W-1:0] addr;
      logic [C_N-1:0][LLR_N-1:0][SELA_W-1:0] sela;
      logic [C_N-1:0]                        mask;
   } cmd_t;

   // a zero shift reproduces the null-circulant addressing (row base + k, lane = select)
   function automatic logic [ADDR_W-1:0] rd_addr(int r, int k, int s, int l);
      return ADDR_W'(r * Z_CYC + (k + s / LLR_N + int'((l + s % LLR_N) >= LLR_N)) % Z_CYC);
   endfunction

   function automatic logic [SELA_W-1:0] rd_sela(int s, int l);
      return SELA_W'((l + s % LLR_N) % LLR_N);
   endfunction
endpackage

// File: rtl/ldpc_dec_cmd_delay.sv
// ldpc_dec_cmd_delay: fixed-latency shift register replaying read commands on the write port
module ldpc_dec_cmd_delay
   import ldpc_dec_addr_pkg::*;
#(
   parameter type T   = cmd_t,
   parameter int  LAT = ENG_LAT
)(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d_valid,
   input  T     d_cmd,
   output logic q_valid,
   output T     q_cmd
);
   logic [LAT-1:0] val;
   T               pipe [LAT];

   always_ff @(posedge clk or posedge rst)
      if (rst) val <= '0;
      else if (en) val <= {val[LAT-2:0], d_valid};

   always_ff @(posedge clk)
      if (en) begin
         pipe[0] <= d_cmd;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end

   assign q_valid = val[LAT-1];
   assign q_cmd   = pipe[LAT-1];
endmodule

// File: rtl/ldpc_dec_mem_addr_gen.sv
// ldpc_dec_mem_addr_gen: walks the QC H matrix layer by layer, issuing node-memory reads
// and replaying them as write-backs after the node-engine latency
module ldpc_dec_mem_addr_gen
   import ldpc_dec_addr_pkg::*;
#(
   parameter int pC            = C_N,
   parameter int pROW_N        = ROW_N,
   parameter int pZ_CYCLES     = Z_CYC,
   parameter int pLLR_BY_CYCLE = LLR_N,
   parameter int pADDR_W       = ADDR_W,
   parameter int pENGINE_LAT   = ENG_LAT,
   parameter int pITER_W       = ITER_W,
   parameter int pTAG_W        = TAG_W
)(
   input  logic                                               iclk,
   input  logic                                               ireset,
   input  logic                                               iclkena,
   input  logic                                               istart,
   input  logic [pITER_W-1:0]                                 initer,
   output logic                                               obusy,
   output logic                                               odone,
   output logic [ROW_W-1:0]                                   oshift_raddr,
   input  logic [pC-1:0][SH_W-1:0]                            ishift,
   output logic [pTAG_W-1:0]                                  ortag,
   output logic [pC-1:0][pLLR_BY_CYCLE-1:0][pADDR_W-1:0]      oraddr,
   output logic [pC-1:0][pLLR_BY_CYCLE-1:0][SELA_W-1:0]       orsela,
   output logic [pC-1:0]                                      ormask,
   output logic                                               owrite,
   output logic [pC-1:0][pLLR_BY_CYCLE-1:0][pADDR_W-1:0]      owaddr,
   output logic [pC-1:0][pLLR_BY_CYCLE-1:0][SELA_W-1:0]       owsela,
   output logic [pC-1:0]                                      owmask
);
   localparam int GAP_W = $clog2(pENGINE_LAT);

   state_t             state, nstate;
   logic [ROW_W-1:0]   r;
   logic [pITER_W-1:0] it, it_last;
   logic [K_W-1:0]     k;
   logic [GAP_W-1:0]   g;
   logic               last_k, last_g, last_row, last_iter, rd, wval;
   cmd_t               rcmd, wcmd;

   assign last_k    = k == K_W'(pZ_CYCLES - 1);
   assign last_g    = g == GAP_W'(pENGINE_LAT - 1);
   assign last_row  = r == ROW_W'(pROW_N - 1);
   assign last_iter = it == it_last;
   assign rd        = state == READ;

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    nstate = istart ? LOAD : IDLE;
         LOAD:    nstate = READ;
         READ:    nstate = !last_k ? READ : (last_row && last_iter) ? DRAIN : GAP;
         GAP:     nstate = last_g ? LOAD : GAP;
         DRAIN:   nstate = last_g ? DONE : DRAIN;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge iclk or posedge ireset)
      if (ireset) begin
         state   <= IDLE;
         r       <= '0;
         it      <= '0;
         it_last <= '0;
         k       <= '0;
         g       <= '0;
      end else if (iclkena) begin
         state <= nstate;
         k     <= (rd && !last_k) ? k + 1'b1 : '0;
         g     <= ((state == GAP || state == DRAIN) && !last_g) ? g + 1'b1 : '0;
         if (state == IDLE && istart) begin
            r       <= '0;
            it      <= '0;
            it_last <= (initer == '0) ? '0 : initer - 1'b1;
         end
         if (state == GAP && last_g) begin
            r  <= last_row ? '0 : r + 1'b1;
            it <= last_row ? it + 1'b1 : it;
         end
      end

   // ishift follows oshift_raddr by one cycle; r is stable from LOAD through READ
   always_comb begin
      rcmd = '0;
      for (int c = 0; c < pC; c++) begin
         rcmd.mask[c] = ishift[c][SH_W-1];
         for (int l = 0; l < pLLR_BY_CYCLE; l++) begin
            rcmd.addr[c][l] = rd_addr(int'(r), int'(k), ishift[c][SH_W-1] ? 0 : int'(ishift[c][SH_W-2:0]), l);
            rcmd.sela[c][l] = rd_sela(ishift[c][SH_W-1] ? 0 : int'(ishift[c][SH_W-2:0]), l);
         end
      end
   end

   ldpc_dec_cmd_delay #(.T(cmd_t), .LAT(pENGINE_LAT)) u_dly (
      .clk     (iclk),
      .rst     (ireset),
      .en      (iclkena),
      .d_valid (rd),
      .d_cmd   (rcmd),
      .q_valid (wval),
      .q_cmd   (wcmd)
   );

   assign obusy        = state != IDLE && state != DONE;
   assign odone        = state == DONE;
   assign oshift_raddr = r;
   assign ortag        = rd ? pTAG_W'({last_iter, last_k}) : '0;
   assign oraddr       = rd ? rcmd.addr : '0;
   assign orsela       = rd ? rcmd.sela : '0;
   assign ormask       = rd ? rcmd.mask : '0;
   assign owrite       = wval;
   assign owaddr       = wval ? wcmd.addr : '0;
   assign owsela       = wval ? wcmd.sela : '0;
   assign owmask       = wval ? wcmd.mask : '0;
endmodule

// File: tb/tb_ldpc_dec_mem_addr_gen.sv
// tb_ldpc_dec_mem_addr_gen: scoreboard bench; expected read/write commands are queued at
// start and a negedge monitor pops them against the enabled-cycle count since start
module tb_ldpc_dec_mem_addr_gen;
   import ldpc_dec_addr_pkg::*;

   localparam int LAYER = 1 + Z_CYC + ENG_LAT;

   logic clk = 0, rst = 1, ena = 1, start = 0;
   logic [ITER_W-1:0] niter = '0;
   logic busy, done, wr;
   logic [ROW_W-1:0] raddr, rom_a = '0;
   logic [C_N-1:0][SH_W-1:0] shift;
   logic [TAG_W-1:0] rtag;
   logic [C_N-1:0][LLR_N-1:0][ADDR_W-1:0] ra, wa;
   logic [C_N-1:0][LLR_N-1:0][SELA_W-1:0] rs, ws;
   logic [C_N-1:0] rm, wm;

   always #5 clk = ~clk;

   ldpc_dec_mem_addr_gen dut (
      .iclk(clk), .ireset(rst), .iclkena(ena), .istart(start), .initer(niter),
      .obusy(busy), .odone(done), .oshift_raddr(raddr), .ishift(shift), .ortag(rtag),
      .oraddr(ra), .orsela(rs), .ormask(rm), .owrite(wr), .owaddr(wa), .owsela(ws), .owmask(wm)
   );

   logic [SH_W-1:0] tab [ROW_N][C_N];
   always @(posedge clk) rom_a <= raddr;
   always_comb for (int c = 0; c < C_N; c++) shift[c] = tab[rom_a][c];

   typedef struct { int rel; cmd_t c; logic [TAG_W-1:0] tag; } exp_t;
   typedef struct { int rel; bit w; int c; int l; int addr; int sela; bit m; } hand_t;
   exp_t  rd_q[$], wr_q[$], me;
   hand_t hq[$], mh;

   int vecs = 0, errs = 0, en_cnt = 0, s0 = 0, total = 0, rel;
   bit armed = 0, last_en = 0, done_seen = 0;

   always @(posedge clk) begin
      if (ena) en_cnt <= en_cnt + 1;
      last_en <= ena;
   end

   // circulant seen as a rotation of the Z*LLR_N LLR positions of a row block
   function automatic exp_t model(int j, int k, int nit);
      exp_t e;
      int r, pos, sv;
      r = j % ROW_N;
      e.rel = j * LAYER + 1 + k;
      e.c = '0;
      for (int c = 0; c < C_N; c++) begin
         e.c.mask[c] = tab[r][c][SH_W-1];
         sv = e.c.mask[c] ? 0 : int'(tab[r][c][SH_W-2:0]);
         for (int l = 0; l < LLR_N; l++) begin
            pos = (k * LLR_N + l + sv) % (Z_CYC * LLR_N);
            e.c.addr[c][l] = ADDR_W'(r * Z_CYC + pos / LLR_N);
            e.c.sela[c][l] = SELA_W'(pos % LLR_N);
         end
      end
      e.tag = TAG_W'({j / ROW_N == nit - 1, k == Z_CYC - 1});
      return e;
   endfunction

   task automatic run_start(input int n_in);
      exp_t e;
      int nit;
      nit = (n_in == 0) ? 1 : n_in;
      total = nit * ROW_N * LAYER;
      for (int j = 0; j < nit * ROW_N; j++)
         for (int k = 0; k < Z_CYC; k++) begin
            e = model(j, k, nit);
            rd_q.push_back(e);
            e.rel += ENG_LAT;
            wr_q.push_back(e);
         end
      @(posedge clk); #1;
      ena = 1; niter = ITER_W'(n_in); start = 1;
      @(posedge clk); #1;
      start = 0; s0 = en_cnt; done_seen = 0; armed = 1;
   endtask

   task automatic wait_end(input bit tog);
      for (int n = 0; n < 3000 && !(done_seen && rd_q.size() == 0 && wr_q.size() == 0); n++) begin
         @(posedge clk); #1;
         if (tog) ena = ~ena;
      end
      vecs++;
      if (!(done_seen && rd_q.size() == 0 && wr_q.size() == 0)) begin
         errs++;
         $display("FAIL run_end got rd_left=%0d wr_left=%0d done_seen=%0b want 0 0 1", rd_q.size(), wr_q.size(), done_seen);
      end
      ena = 1;
      repeat (3) @(posedge clk);
      #1 armed = 0;
      rd_q.delete(); wr_q.delete(); hq.delete();
   endtask

   always @(negedge clk) begin
      if (armed && last_en) begin
         rel = en_cnt - s0;
         vecs++;
         if (busy !== (rel < total) || done !== (rel == total)) begin
            errs++;
            $display("FAIL ctrl rel=%0d got busy=%0b done=%0b want busy=%0b done=%0b", rel, busy, done, rel < total, rel == total);
         end
         if (done && rel == total) done_seen = 1;
         if (rd_q.size() != 0 && rd_q[0].rel == rel) begin
            me = rd_q.pop_front();
            vecs++;
            if (ra !== me.c.addr || rs !== me.c.sela || rm !== me.c.mask || rtag !== me.tag) begin
               errs++;
               $display("FAIL rd rel=%0d got addr=%h sela=%h mask=%h tag=%h want addr=%h sela=%h mask=%h tag=%h",
                        rel, ra, rs, rm, rtag, me.c.addr, me.c.sela, me.c.mask, me.tag);
            end
         end
         if (wr) begin
            vecs++;
            if (wr_q.size() == 0) begin
               errs++;
               $display("FAIL wr_extra rel=%0d got owrite=1 want 0", rel);
            end else begin
               me = wr_q.pop_front();
               if (me.rel != rel || wa !== me.c.addr || ws !== me.c.sela || wm !== me.c.mask) begin
                  errs++;
                  $display("FAIL wr rel=%0d want_rel=%0d got addr=%h sela=%h mask=%h want addr=%h sela=%h mask=%h",
                           rel, me.rel, wa, ws, wm, me.c.addr, me.c.sela, me.c.mask);
               end
            end
         end else if (wr_q.size() != 0 && wr_q[0].rel == rel) begin
            me = wr_q.pop_front();
            vecs++; errs++;
            $display("FAIL wr_missing rel=%0d got owrite=0 want 1", rel);
         end
         while (hq.size() != 0 && hq[0].rel == rel) begin
            mh = hq.pop_front();
            vecs++;
            if ((mh.w ? int'(wa[mh.c][mh.l]) : int'(ra[mh.c][mh.l])) != mh.addr ||
                (mh.w ? int'(ws[mh.c][mh.l]) : int'(rs[mh.c][mh.l])) != mh.sela ||
                (mh.w ? wm[mh.c] : rm[mh.c]) != mh.m || (mh.w && !wr)) begin
               errs++;
               $display("FAIL hand rel=%0d w=%0b c=%0d l=%0d got addr=%0d sela=%0d mask=%0b want addr=%0d sela=%0d mask=%0b",
                        rel, mh.w, mh.c, mh.l,
                        mh.w ? int'(wa[mh.c][mh.l]) : int'(ra[mh.c][mh.l]),
                        mh.w ? int'(ws[mh.c][mh.l]) : int'(rs[mh.c][mh.l]),
                        mh.w ? wm[mh.c] : rm[mh.c], mh.addr, mh.sela, mh.m);
            end
         end
      end else if (!armed) begin
         vecs++;
         if (wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL idle got owrite=%0b busy=%0b done=%0b want 0 0 0", wr, busy, done);
         end
      end
   end

   initial begin
      for (int r = 0; r < ROW_N; r++)
         for (int c = 0; c < C_N; c++) tab[r][c] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      vecs++;
      if ({busy, done, wr, raddr, rtag, ra, rs, rm, wa, ws, wm} !== '0) begin
         errs++;
         $display("FAIL reset_state got busy=%0b done=%0b owrite=%0b raddr=%0d tag=%h want all zero", busy, done, wr, raddr, rtag);
      end
      tab[0][3] = 6'h20;
      tab[1][0] = 6'd5; tab[1][1] = 6'd31; tab[1][2] = 6'd1; tab[1][3] = 6'h3F;
      for (int c = 0; c < C_N; c++) begin
         tab[2][c] = SH_W'(c * 3);
         tab[3][c] = SH_W'(31 - 2 * c);
      end
      hq.push_back('{1, 0, 0, 0, 0, 0, 0});
      hq.push_back('{1, 0, 0, 1, 0, 1, 0});
      hq.push_back('{1, 0, 3, 1, 0, 1, 1});
      hq.push_back('{5, 0, 3, 1, 4, 1, 1});
      hq.push_back('{10, 1, 3, 0, 0, 0, 1});
      hq.push_back('{16, 0, 0, 1, 15, 1, 0});
      hq.push_back('{27, 0, 0, 0, 18, 1, 0});
      hq.push_back('{27, 0, 0, 1, 19, 0, 0});
      hq.push_back('{27, 0, 3, 0, 16, 0, 1});
      hq.push_back('{36, 1, 0, 0, 18, 1, 0});
      hq.push_back('{42, 0, 0, 1, 18, 0, 0});
      hq.push_back('{42, 0, 1, 0, 30, 1, 0});
      run_start(1); wait_end(0);
      run_start(2); wait_end(0);
      run_start(0); wait_end(0);
      run_start(1);
      repeat (30) @(posedge clk);
      #1 rst = 1; armed = 0;
      rd_q.delete(); wr_q.delete();
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0 || wr !== 1'b0) begin
         errs++;
         $display("FAIL reset_mid got busy=%0b owrite=%0b want 0 0", busy, wr);
      end
      @(posedge clk); #1 rst = 0;
      repeat (3) @(posedge clk);
      run_start(1); wait_end(0);
      run_start(1); wait_end(1);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
